// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write-port arbiter: FSM encodings and default sizing.
package fifo_arb_pkg;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_MAX_BURST  = 16;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Index width with a floor of one bit, so single-entry configurations still elaborate.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of req scanning upward from base+1, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    base,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && req[j] && (j == ((32'(base) + i) % NUM_REQ))) begin
          found = 1'b1;
          idx   = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter locking one FIFO write port to a single producer per burst.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_BURST  = DEF_MAX_BURST,
  parameter int unsigned ID_W       = clog2_min1(NUM_REQ),
  parameter int unsigned CNT_W      = clog2_min1(MAX_BURST)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_i,
  input  logic [NUM_REQ-1:0]             req_last_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic                           fifo_full_i,
  output logic                           fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]          fifo_wr_data_o,
  output logic                           busy_o,
  output logic [ID_W-1:0]                grant_id_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  logic [0:0]            state_q, state_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic [ID_W-1:0]       last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;

  logic                  pick_found;
  logic [ID_W-1:0]       pick_idx;
  logic                  in_burst;
  logic                  gnt_valid;
  logic                  gnt_last;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  accept;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req   (req_valid_i),
    .base  (last_grant_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Route the granted producer's lanes.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_q == ID_W'(k)) begin
        gnt_valid = req_valid_i[k];
        gnt_last  = req_last_i[k];
        gnt_data  = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign in_burst = (state_q == ST_BURST);
  // Ready depends only on state and full, never on valid.
  assign accept   = in_burst & gnt_valid & ~fifo_full_i;

  always_comb begin
    req_ready_o = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      req_ready_o[k] = in_burst && (grant_q == ID_W'(k)) && !fifo_full_i;
    end
  end

  assign fifo_wr_en_o   = accept;
  assign fifo_wr_data_o = in_burst ? gnt_data : '0;
  assign busy_o         = in_burst;
  assign grant_id_o     = grant_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          // A capped burst hands priority onward so waiting producers go first.
          if (gnt_last || (beat_cnt_q == LAST_CNT)) begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer queues, expected-write scoreboard, single-burst table and corner sequences.
module tb_fifo_wr_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned MB  = 16;
  localparam int unsigned IDW = 2;
  localparam int unsigned PD  = 64;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NR-1:0]        req_valid_i;
  logic [NR*DW-1:0]     req_data_i;
  logic [NR-1:0]        req_last_i;
  logic [NR-1:0]        req_ready_o;
  logic                 fifo_full_i;
  logic                 fifo_wr_en_o;
  logic [DW-1:0]        fifo_wr_data_o;
  logic                 busy_o;
  logic [IDW-1:0]       grant_id_o;

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_data_i     (req_data_i),
    .req_last_i     (req_last_i),
    .req_ready_o    (req_ready_o),
    .fifo_full_i    (fifo_full_i),
    .fifo_wr_en_o   (fifo_wr_en_o),
    .fifo_wr_data_o (fifo_wr_data_o),
    .busy_o         (busy_o),
    .grant_id_o     (grant_id_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  typedef struct { logic [DW-1:0] d; int id; } exp_t;
  typedef struct { int id; int len; int bursts; } vec_t;

  beat_t          pmem [NR][PD];
  int             phead [NR];
  int             ptail [NR];
  logic [NR-1:0]  en_r;
  logic           full_r;
  exp_t           sb [$];
  int             order [$];
  int             n_pass = 0;
  int             n_total = 0;
  int             n_wr = 0;
  int             idle_run = 0;
  logic           prev_busy = 1'b0;
  logic           gap_chk = 1'b0;
  logic           s_busy = 1'b0;
  logic           s_wr_en = 1'b0;
  logic [NR-1:0]  s_ready = '0;
  logic [IDW-1:0] s_grant = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [DW-1:0] mk(input int k, input int b, input int i);
    return {8'(k), 8'(b), 16'(i)};
  endfunction

  task automatic load_prod(input int k, input int len, input int b);
    for (int i = 0; i < len; i++) begin
      pmem[k][ptail[k] % PD] = '{d: mk(k, b, i), l: (i == len - 1)};
      ptail[k]++;
    end
  endtask

  task automatic expect_beats(input int k, input int b, input int from, input int to);
    for (int i = from; i < to; i++) sb.push_back('{d: mk(k, b, i), id: k});
  endtask

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      req_valid_i[k]         = en_r[k] && (phead[k] != ptail[k]);
      req_data_i[k*DW +: DW] = pmem[k][phead[k] % PD].d;
      req_last_i[k]          = pmem[k][phead[k] % PD].l;
    end
    fifo_full_i = full_r;
  endtask

  function automatic bit idle_all();
    bit e = (sb.size() == 0) && !s_busy;
    for (int k = 0; k < NR; k++) if (phead[k] != ptail[k]) e = 1'b0;
    return e;
  endfunction

  // One clock: sample and score at negedge, retire accepted beats after posedge.
  task automatic step();
    logic [NR-1:0] acc;
    exp_t          e;
    @(negedge clk);
    s_busy  = busy_o;
    s_wr_en = fifo_wr_en_o;
    s_ready = req_ready_o;
    s_grant = grant_id_o;
    acc     = req_valid_i & req_ready_o;
    check("wr_en_vs_handshake", 32'(fifo_wr_en_o), 32'(|acc));
    check("no_write_when_full", 32'(fifo_wr_en_o & fifo_full_i), 32'd0);
    if (!busy_o) begin
      check("idle_ready", 32'(req_ready_o), 32'd0);
      check("idle_data", fifo_wr_data_o, 32'd0);
    end
    if (fifo_wr_en_o) begin
      n_wr++;
      if (sb.size() == 0) fail_now("unexpected_write");
      else begin
        e = sb.pop_front();
        check("wr_data", fifo_wr_data_o, e.d);
        check("wr_grant", 32'(grant_id_o), 32'(e.id));
      end
    end
    if (busy_o && !prev_busy) begin
      order.push_back(int'(grant_id_o));
      if (gap_chk && order.size() > 1) check("idle_gap", 32'(idle_run), 32'd1);
      idle_run = 0;
    end
    if (!busy_o) idle_run++;
    prev_busy = busy_o;
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) if (acc[k]) phead[k]++;
    drive();
  endtask

  task automatic run_done(input int budget, input string name);
    bit done = 1'b0;
    for (int s = 0; s < budget && !done; s++) begin
      step();
      done = idle_all();
    end
    if (!done) fail_now({name, "_timeout"});
  endtask

  task automatic wait_writes(input int n, input int budget, input string name);
    int  base = n_wr;
    bit  ok = 1'b0;
    for (int s = 0; s < budget && !ok; s++) begin
      step();
      if (n_wr - base >= n) ok = 1'b1;
    end
    if (!ok) fail_now({name, "_timeout"});
  endtask

  task automatic check_order(input string name, input int n,
                             input int e0, input int e1, input int e2, input int e3, input int e4);
    int e [5];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
    check({name, "_count"}, 32'(order.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < order.size()) check({name, "_grant"}, 32'(order[i]), 32'(e[i]));
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    full_r = 1'b0;
    en_r   = '1;
    for (int k = 0; k < NR; k++) begin
      phead[k] = 0;
      ptail[k] = 0;
    end
    sb.delete();
    order.delete();
    idle_run  = 0;
    prev_busy = 1'b0;
    gap_chk   = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_grant", 32'(grant_id_o), 32'd0);
    check("rst_wr_en", 32'(fifo_wr_en_o), 32'd0);
    check("rst_data", fifo_wr_data_o, 32'd0);
    check("rst_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t vecs [5];
    int   wr0, ord0, first;
    bit   done;

    vecs[0] = '{id: 2, len: 3,  bursts: 1};
    vecs[1] = '{id: 0, len: 1,  bursts: 1};
    vecs[2] = '{id: 3, len: 16, bursts: 1};
    vecs[3] = '{id: 1, len: 17, bursts: 2};
    vecs[4] = '{id: 0, len: 5,  bursts: 1};

    rst_n       = 1'b0;
    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;
    fifo_full_i = 1'b0;
    do_reset();

    // Single-requester bursts: latency, burst count, beat count, grant holding.
    for (int v = 0; v < 5; v++) begin
      load_prod(vecs[v].id, vecs[v].len, v);
      expect_beats(vecs[v].id, v, 0, vecs[v].len);
      drive();
      wr0   = n_wr;
      ord0  = order.size();
      first = 0;
      done  = 1'b0;
      for (int s = 1; s <= 100 && !done; s++) begin
        step();
        if (first == 0 && n_wr != wr0) first = s;
        done = idle_all();
      end
      if (!done) fail_now("vec_timeout");
      check("vec_first_write_step", 32'(first), 32'd2);
      check("vec_bursts", 32'(order.size() - ord0), 32'(vecs[v].bursts));
      check("vec_beats", 32'(n_wr - wr0), 32'(vecs[v].len));
      check("vec_grant_hold", 32'(s_grant), 32'(vecs[v].id));
    end

    // All four requesters, 2-beat bursts: rotation 0,1,2,3,0 with one idle cycle between.
    do_reset();
    load_prod(0, 2, 0); load_prod(0, 2, 1);
    load_prod(1, 2, 0); load_prod(2, 2, 0); load_prod(3, 2, 0);
    expect_beats(0, 0, 0, 2); expect_beats(1, 0, 0, 2); expect_beats(2, 0, 0, 2);
    expect_beats(3, 0, 0, 2); expect_beats(0, 1, 0, 2);
    gap_chk = 1'b1;
    drive();
    run_done(100, "rr");
    check_order("rr_order", 5, 0, 1, 2, 3, 0);

    // Burst capped at MAX_BURST: waiting requester 3 goes before the remainder of 1.
    do_reset();
    load_prod(1, 20, 0);
    load_prod(3, 3, 0);
    expect_beats(1, 0, 0, 16); expect_beats(3, 0, 0, 3); expect_beats(1, 0, 16, 20);
    drive();
    run_done(100, "cap");
    check_order("cap_order", 3, 1, 3, 1, 0, 0);

    // FIFO full for beats 2-4: stall with grant held, no writes.
    do_reset();
    load_prod(2, 6, 0);
    expect_beats(2, 0, 0, 6);
    drive();
    wr0 = n_wr;
    wait_writes(1, 20, "full_pre");
    full_r = 1'b1;
    drive();
    for (int s = 0; s < 3; s++) begin
      step();
      check("full_wr_en", 32'(s_wr_en), 32'd0);
      check("full_ready", 32'(s_ready), 32'd0);
      check("full_grant", 32'(s_grant), 32'd2);
      check("full_busy", 32'(s_busy), 32'd1);
    end
    full_r = 1'b0;
    drive();
    run_done(50, "full");
    check("full_total_beats", 32'(n_wr - wr0), 32'd6);

    // Granted requester drops valid mid-burst while requester 0 waits.
    do_reset();
    load_prod(2, 6, 0);
    expect_beats(2, 0, 0, 6);
    drive();
    wait_writes(2, 20, "drop_pre");
    load_prod(0, 2, 0);
    expect_beats(0, 0, 0, 2);
    en_r[2] = 1'b0;
    drive();
    for (int s = 0; s < 5; s++) begin
      step();
      check("drop_wr_en", 32'(s_wr_en), 32'd0);
      check("drop_grant", 32'(s_grant), 32'd2);
      check("drop_busy", 32'(s_busy), 32'd1);
    end
    en_r[2] = 1'b1;
    drive();
    run_done(50, "drop");
    check_order("drop_order", 2, 2, 0, 0, 0, 0);

    // Asynchronous reset during beat 3 of 8, then requester 0 wins first.
    do_reset();
    load_prod(2, 8, 0);
    expect_beats(2, 0, 0, 8);
    drive();
    wait_writes(2, 20, "arst_pre");
    #2;
    check("arst_pre_busy", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_wr_en", 32'(fifo_wr_en_o), 32'd0);
    check("arst_ready", 32'(req_ready_o), 32'd0);
    check("arst_grant", 32'(grant_id_o), 32'd0);
    check("arst_data", fifo_wr_data_o, 32'd0);
    do_reset();
    load_prod(2, 2, 1);
    load_prod(0, 2, 0);
    expect_beats(0, 0, 0, 2); expect_beats(2, 1, 0, 2);
    drive();
    run_done(50, "arst");
    check_order("arst_order", 2, 0, 2, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
